// File: rtl/apb_master_n.sv
// apb_master_n: APB3 master bridge, NUM_SLAVES slaves on a fixed-stride map.
// Define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase by TIMEOUT_CYCLES.
module apb_master_n #(
    parameter int unsigned NUM_SLAVES     = 5,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned SLOT_BITS      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       transfer,
    input  logic                       write,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic                       ready,
    output logic [31:0]                rdata,
    output logic                       error,
    output logic [31:0]                PADDR,
    output logic                       PWRITE,
    output logic [31:0]                PWDATA,
    output logic                       PENABLE,
    output logic [NUM_SLAVES-1:0]      PSEL,
    input  logic [NUM_SLAVES*32-1:0]   PRDATA,
    input  logic [NUM_SLAVES-1:0]      PREADY,
    input  logic [NUM_SLAVES-1:0]      PSLVERR
);

    localparam int IW = 4;
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    function automatic logic dec_hit(input logic [31:0] a);
        logic [31:0] slot;
        slot = (a - BASE_ADDR) >> SLOT_BITS;
        return (a >= BASE_ADDR) && (slot < 32'(NUM_SLAVES));
    endfunction

    function automatic logic [IW-1:0] dec_idx(input logic [31:0] a);
        logic [31:0] slot;
        slot = (a - BASE_ADDR) >> SLOT_BITS;
        return slot[IW-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [IW-1:0]         cur_idx;
    logic [NUM_SLAVES-1:0] psel_a;
    logic                  sel_rdy;
    logic                  sel_err;
    logic [31:0]           sel_rd;
    logic                  expire;
    logic                  take;

    assign cur_idx = dec_idx(paddr_q);

    always_comb begin
        psel_a  = '0;
        sel_rdy = 1'b0;
        sel_err = 1'b0;
        sel_rd  = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (cur_idx == IW'(i)) begin
                psel_a[i] = 1'b1;
                sel_rdy   = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rd    = PRDATA[32*i +: 32];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign expire = (state_q == ACCESS) && !sel_rdy && (cnt_q == TO_LIM);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP)
            cnt_d = '0;
        else if (state_q == ACCESS && !sel_rdy)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_to;
    assign unused_to = ^TO_LIM;
    assign expire    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        ready    = 1'b0;
        error    = 1'b0;
        rdata    = '0;
        PENABLE  = 1'b0;
        PSEL     = '0;
        take     = 1'b0;
        case (state_q)
            IDLE: take = transfer;
            SETUP: begin
                PSEL    = psel_a;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = psel_a;
                PENABLE = 1'b1;
                if (sel_rdy) begin
                    ready   = 1'b1;
                    error   = sel_err;
                    rdata   = pwrite_q ? '0 : sel_rd;
                    take    = transfer;
                    state_d = IDLE;
                end else if (expire) begin
                    ready   = 1'b1;
                    error   = 1'b1;
                    take    = transfer;
                    state_d = IDLE;
                end
            end
            DECERR: begin
                ready   = 1'b1;
                error   = 1'b1;
                take    = transfer;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new request is accepted while idle or in any completing cycle
        if (take) begin
            paddr_d  = addr;
            pwrite_d = write;
            pwdata_d = wdata;
            state_d  = dec_hit(addr) ? SETUP : DECERR;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_apb_master_n.sv
// tb_apb_master_n: directed vector bench for apb_master_n (5 slaves).
// Timeout sequence depends on APB_MASTER_TIMEOUT_EN.
module tb_apb_master_n;

    localparam int NS = 5;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b0;
    logic            transfer = 1'b0;
    logic            write = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic            ready;
    logic [31:0]     rdata;
    logic            error;
    logic [31:0]     PADDR;
    logic            PWRITE;
    logic [31:0]     PWDATA;
    logic            PENABLE;
    logic [NS-1:0]   PSEL;
    logic [NS*32-1:0] PRDATA = '0;
    logic [NS-1:0]   PREADY = '1;
    logic [NS-1:0]   PSLVERR = '0;

    apb_master_n #(
        .NUM_SLAVES(NS),
        .BASE_ADDR(32'h1000_0000),
        .SLOT_BITS(12),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .error(error),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad = 0;
    logic [31:0] mem [NS];

    typedef struct {
        logic          wr;
        logic [31:0]   a;
        logic [31:0]   wd;
        int            waits;
        logic          serr;
        logic [31:0]   ovr;
        int            lat;
        logic          err;
        logic [31:0]   rd;
        logic [NS-1:0] psel;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic run(input int id, input vec_t v);
        int s, acc, lat, pen;
        logic stable, e;
        logic [31:0] r;
        logic [NS-1:0] psor;
        s = -1;
        for (int i = 0; i < NS; i++) if (v.psel[i]) s = i;
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = mem[i];
        PSLVERR = '0;
        if (s >= 0) begin
            if (v.ovr != 0) PRDATA[32*s +: 32] = v.ovr;
            PSLVERR[s] = v.serr;
        end
        transfer = 1'b1; write = v.wr; addr = v.a; wdata = v.wd;
        acc = 0; lat = -1; pen = 0; psor = '0; stable = 1'b1;
        e = 1'b0; r = '0;
        for (int c = 0; c < 40; c++) begin
            PREADY = '1;
            if (PENABLE) begin
                if (acc < v.waits) PREADY = '0;
                acc++;
            end
            @(negedge PCLK);
            psor |= PSEL;
            if (PENABLE) pen++;
            if (c > 0 && (PADDR !== v.a || PWDATA !== v.wd || PWRITE !== v.wr))
                stable = 1'b0;
            if (ready) begin
                lat = c; e = error; r = rdata;
            end
            step();
            transfer = 1'b0;
            if (lat >= 0) break;
        end
        PREADY = '1;
        PSLVERR = '0;
        if (lat >= 0 && v.wr && s >= 0 && !v.serr) mem[s] = v.wd;
        chk($sformatf("v%0d_lat", id), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_err", id), 32'(e), 32'(v.err));
        chk($sformatf("v%0d_rdata", id), r, v.rd);
        chk($sformatf("v%0d_psel", id), 32'(psor), 32'(v.psel));
        chk($sformatf("v%0d_penable", id), 32'(pen),
            32'((v.psel != 0) ? v.waits + 1 : 0));
        chk($sformatf("v%0d_stable", id), 32'(stable), 32'd1);
    endtask

    task automatic start_hung();
        PREADY = '0;
        transfer = 1'b1; write = 1'b0;
        addr = 32'h1000_1000; wdata = 32'h0;
        step();
        transfer = 1'b0;
        step();
    endtask

    logic [31:0]   ba [3];
    logic [NS-1:0] bt [3];
    int done_at [3];

    initial begin
        int k, cur, pbad, hbad, lat;
        logic e;
        logic [31:0] r;
        for (int i = 0; i < NS; i++) mem[i] = 32'h1100_0000 + 32'(i);

        tv[0] = '{1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 2, 1'b0, 32'h0, 5'b00100};
        tv[1] = '{1'b0, 32'h1000_2004, 32'h0, 0, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 5'b00100};
        tv[2] = '{1'b1, 32'h1000_0010, 32'hA5A5_0001, 3, 1'b0, 32'h0, 5, 1'b0, 32'h0, 5'b00001};
        tv[3] = '{1'b0, 32'h1000_0010, 32'h0, 1, 1'b0, 32'h0, 3, 1'b0, 32'hA5A5_0001, 5'b00001};
        tv[4] = '{1'b0, 32'h1000_5000, 32'h0, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};
        tv[5] = '{1'b0, 32'h0FFF_FFFC, 32'h0, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};
        tv[6] = '{1'b0, 32'h1000_3000, 32'h0, 0, 1'b1, 32'h1234, 2, 1'b1, 32'h1234, 5'b01000};
        tv[7] = '{1'b0, 32'h1000_3008, 32'h0, 0, 1'b0, 32'h0, 2, 1'b0, 32'h1100_0003, 5'b01000};
        tv[8] = '{1'b0, 32'h1000_4FFC, 32'h0, 0, 1'b0, 32'h0, 2, 1'b0, 32'h1100_0004, 5'b10000};
        tv[9] = '{1'b1, 32'h2000_0000, 32'h55, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 5'b00000};

        step();
        step();
        @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_penable", 32'(PENABLE), 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwrite", 32'(PWRITE), 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        step();
        PRESET = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run(i, tv[i]);

        // Back-to-back: next request offered in each completing cycle
        ba[0] = 32'h1000_1000; bt[0] = 5'b00010;
        ba[1] = 32'h1000_4000; bt[1] = 5'b10000;
        ba[2] = 32'h1000_1004; bt[2] = 5'b00010;
        for (int i = 0; i < 3; i++) done_at[i] = -1;
        for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = mem[i];
        k = 0; cur = 0; pbad = 0;
        transfer = 1'b1; write = 1'b0; addr = ba[0];
        for (int c = 0; c < 20 && k < 3; c++) begin
            if (c > 0) begin
                if (PENABLE && cur + 1 < 3) begin
                    transfer = 1'b1; addr = ba[cur + 1];
                end else begin
                    transfer = 1'b0;
                end
            end
            @(negedge PCLK);
            if (PSEL != 0 && PSEL !== bt[cur]) pbad++;
            if (ready) begin
                done_at[k] = c;
                k++;
            end
            step();
            cur = (k < 3) ? k : 2;
        end
        transfer = 1'b0;
        chk("b2b_done0", 32'(done_at[0]), 32'd2);
        chk("b2b_done1", 32'(done_at[1]), 32'd4);
        chk("b2b_done2", 32'(done_at[2]), 32'd6);
        chk("b2b_psel_glitch", 32'(pbad), 32'd0);

        start_hung();
`ifdef APB_MASTER_TIMEOUT_EN
        lat = -1; e = 1'b0; r = 32'hFFFF_FFFF;
        for (int c = 2; c < 40; c++) begin
            @(negedge PCLK);
            if (ready) begin
                lat = c; e = error; r = rdata;
                break;
            end
            step();
        end
        chk("to_lat", 32'(lat), 32'd9);
        chk("to_err", 32'(e), 32'd1);
        chk("to_rdata", r, 32'h0);
        step();
        @(negedge PCLK);
        chk("to_idle_penable", 32'(PENABLE), 32'd0);
        chk("to_idle_psel", 32'(PSEL), 32'd0);
        step();
        start_hung();
`else
        hbad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge PCLK);
            if (!PENABLE || PSEL !== 5'b00010 || ready) hbad++;
            step();
        end
        chk("noto_still_access", 32'(hbad), 32'd0);
`endif

        // Async reset in ACCESS abandons the transfer without a ready pulse
        #1;
        PRESET = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        hbad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            if (ready) hbad++;
        end
        chk("arst_no_ready", 32'(hbad), 32'd0);
        step();
        PREADY = '1;
        PRESET = 1'b1;
        step();
        run(10, tv[8]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_n.md
# apb_master_n

Parametrised APB3 master bridge for the RV32I multicycle MCU. It converts the CPU's single-request data-bus handshake (transfer/ready) into APB SETUP/ACCESS phases toward `NUM_SLAVES` peripherals on a fixed-stride address map. It adds two things the fixed five-slave master lacks: PSLVERR propagation and decode-error responses. As a compile option it also provides an ACCESS-phase timeout, so a hung peripheral cannot stall the core.

## Interface
- `NUM_SLAVES`, 5, number of APB slaves, 1..16
- `BASE_ADDR`, 32'h1000_0000, address of slave 0 slot
- `SLOT_BITS`, 12, log2 of slot size (4 KB per slave)
- `TIMEOUT_CYCLES`, 255, ACCESS cycles before forced error, 1..65535
- `PCLK` in 1: single clock, rising edge
- `PRESET` in 1: asynchronous, active-low reset
- `transfer` in 1: request strobe from CPU, sampled only when bridge is idle or completing
- `write` in 1: 1 = write, 0 = read
- `addr` in 32: byte address
- `wdata` in 32: write data
- `ready` out 1: transfer complete, one cycle per transfer
- `rdata` out 32: read data, valid while `ready`=1
- `error` out 1: PSLVERR, decode error or timeout; valid while `ready`=1
- `PADDR` out 32: latched address
- `PWRITE` out 1: latched direction
- `PWDATA` out 32: latched write data
- `PENABLE` out 1: ACCESS phase indicator
- `PSEL` out NUM_SLAVES: one-hot slave select
- `PRDATA` in NUM_SLAVES*32: slave i read data at bits [32i+31:32i]
- `PREADY` in NUM_SLAVES: per-slave ready
- `PSLVERR` in NUM_SLAVES: per-slave error

## Operation
- Decode: `idx = (addr - BASE_ADDR) >> SLOT_BITS`, computed on the latched address.
  - Hit when `addr >= BASE_ADDR` and `idx < NUM_SLAVES`; otherwise miss.
- FSM states: IDLE, SETUP, ACCESS, DECERR.
- IDLE:
  - On `transfer`=1, latch addr/write/wdata into PADDR/PWRITE/PWDATA.
  - Go to SETUP on a hit, or DECERR on a miss.
- SETUP: `PSEL[idx]`=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: `PSEL[idx]`=1, PENABLE=1.
  - When `PREADY[idx]`=1: ready=1, rdata=`PRDATA[idx]`, error=`PSLVERR[idx]`.
  - Then go to SETUP if `transfer`=1 in that same cycle (back-to-back; new request is latched), else IDLE.
- DECERR: no PSEL asserted; ready=1, error=1, rdata=0 for one cycle.
  - Next state as in ACCESS completion (SETUP/DECERR on `transfer`, else IDLE).
- `transfer` in SETUP, or in ACCESS without completion, is ignored. The CPU holds off until `ready`.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the completing ACCESS cycle. They hold their last value in IDLE.
- Writes: rdata=0 when ready.

## Timing
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, ready=0, rdata=0, error=0, state IDLE, timeout counter 0.
- Async reset mid-transfer: PSEL and PENABLE drop immediately and the transfer is abandoned; no `ready` is issued.
- Zero-wait slave: transfer at cycle N, SETUP N+1, ACCESS with ready=1 at N+2. Latency is 2 cycles.
- Each wait cycle (`PREADY`=0) adds 1 cycle.
- Decode miss: ready=1 at N+1.
- Back-to-back zero-wait transfers: one completion every 2 cycles.
- ready/rdata/error are combinational from the selected slave in ACCESS, and registered-state-driven in DECERR.
- PSLVERR is sampled only in the cycle where `PREADY[idx]`=1.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle with `PREADY[idx]`=0.
  - When it reaches TIMEOUT_CYCLES, the bridge forces ready=1, error=1, rdata=0 for one cycle. PSEL and PENABLE drop on the next edge and the FSM leaves ACCESS.
  - A PREADY that coincides with the expiry cycle wins: normal completion, error=`PSLVERR[idx]`.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

## Test plan
- Write then read, slave 2 zero-wait: write 0x1000_2004 with 0xDEAD_BEEF.
  - SETUP and ACCESS each last 1 cycle with PSEL=5'b00100; ready at cycle +2, error=0.
  - Read of the same address returns 0xDEAD_BEEF.
- Wait states: slave 0 holds PREADY low 3 cycles.
  - ready appears exactly at cycle +5.
  - PADDR/PWDATA are stable throughout and PENABLE stays high for 4 cycles.
- Decode miss: read 0x1000_5000 (NUM_SLAVES=5) and 0x0FFF_FFFC.
  - PSEL stays 0; ready=1, error=1, rdata=0 at cycle +1.
- Slave error: slave 3 returns PREADY=1, PSLVERR=1, PRDATA=0x1234.
  - ready=1, error=1, rdata=0x1234.
  - Next transfer completes with error=0.
- Back-to-back: `transfer` asserted in every ready cycle to slaves 1, 4, 1.
  - Completions land at cycles +2, +4, +6; PSEL never glitches to a non-target slave.
- Timeout (macro defined, TIMEOUT_CYCLES=8): slave 1 never raises PREADY.
  - ready=1, error=1 after 8 ACCESS cycles, then IDLE.
- Timeout (macro undefined): the bridge is still in ACCESS after 1000 cycles.
- Async reset asserted in ACCESS: PSEL=0 and PENABLE=0 immediately, with no ready pulse.
